match_ratio_core: RTL

//  Parametrised brute-force descriptor matcher. Streams N slave descriptors against one held main descriptor.

---
 rtl/match_pkg.sv | 21 ++
 rtl/hdc_param.sv | 68 ++++++
 rtl/match_ratio_core.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/match_pkg.sv
// Shared types and constants for the descriptor matcher.
package match_pkg;

  // Width needed to hold a Hamming distance of 0..des_w inclusive.
  function automatic int hd_width(input int des_w);
    return $clog2(des_w) + 1;
  endfunction

  // Search control states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    DRAIN  = 3'd2,
    DONE   = 3'd3,
    HOLD   = 3'd4
  } match_state_e;

  // "No candidate yet" distance; users slice it down to their HD_W.
  localparam logic [63:0] HD_SENTINEL = '1;

endpackage

// File: rtl/hdc_param.sv
// Pipelined Hamming distance (popcount of a_i ^ b_i) with a fixed latency
// of HDC_LAT cycles. Stage 1 counts 16-bit groups, stage 2 sums the groups,
// and any remaining latency is plain delay registers.
module hdc_param
  import match_pkg::*;
#(
  parameter int DES_W   = 128,
  parameter int HDC_LAT = 3,
  parameter int HD_W    = hd_width(DES_W)
) (
  input  logic             clk_i,
  input  logic [DES_W-1:0] a_i,
  input  logic [DES_W-1:0] b_i,
  output logic [HD_W-1:0]  hd_o
);

  localparam int GRP  = 16;
  localparam int NGRP = (DES_W + GRP - 1) / GRP;
  localparam int GW   = $clog2(GRP) + 1;

  logic [DES_W-1:0] diff;
  assign diff = a_i ^ b_i;

  if (HDC_LAT == 1) begin : g_single
    logic [HD_W-1:0] hd_d;
    logic [HD_W-1:0] hd_q;

    // Full popcount in one cycle.
    always_comb begin
      hd_d = '0;
      for (int i = 0; i < DES_W; i++) hd_d = hd_d + HD_W'(diff[i]);
    end

    // Single output register.
    always_ff @(posedge clk_i) hd_q <= hd_d;

    assign hd_o = hd_q;
  end else begin : g_tree
    logic [GW-1:0]   grp_d  [NGRP];
    logic [GW-1:0]   grp_q  [NGRP];
    logic [HD_W-1:0] sum_d;
    logic [HD_W-1:0] pipe_q [HDC_LAT-1];

    // Per-group bit counts.
    always_comb begin
      for (int g = 0; g < NGRP; g++) grp_d[g] = '0;
      for (int i = 0; i < DES_W; i++) grp_d[i/GRP] = grp_d[i/GRP] + GW'(diff[i]);
    end

    // Group count register.
    always_ff @(posedge clk_i) grp_q <= grp_d;

    // Sum of the registered group counts.
    always_comb begin
      sum_d = '0;
      for (int g = 0; g < NGRP; g++) sum_d = sum_d + HD_W'(grp_q[g]);
    end

    // Sum register followed by delay stages to reach HDC_LAT.
    always_ff @(posedge clk_i) begin
      pipe_q[0] <= sum_d;
      for (int k = 1; k < HDC_LAT - 1; k++) pipe_q[k] <= pipe_q[k-1];
    end

    assign hd_o = pipe_q[HDC_LAT-2];
  end

endmodule

// File: rtl/match_ratio_core.sv
// Brute-force descriptor matcher: streams slave descriptors against one held
// main descriptor, tracks best/second-best Hamming distance, and reports one
// result per search with a threshold + ratio test verdict.
//
// Handshakes: a slave beat transfers on a cycle where s_valid && s_ready;
// s_ready depends only on state (high in SEARCH). The result is offered with
// m_valid held high and all result outputs stable until the cycle where
// m_valid && m_ready, after which the core returns to IDLE.
module match_ratio_core
  import match_pkg::*;
#(
  parameter int DES_W   = 128,
  parameter int COOR_W  = 20,
  parameter int IDX_W   = 10,
  parameter int HD_W    = hd_width(DES_W),
  parameter int HDC_LAT = 3
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    start,
  input  logic [COOR_W+DES_W-1:0] coor_des_main,
  input  logic [HD_W-1:0]         max_hd,
  input  logic [3:0]              ratio_q4,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  input  logic [COOR_W+DES_W-1:0] coor_des_slave,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [IDX_W-1:0]        best_idx,
  output logic [COOR_W-1:0]       best_coor,
  output logic [HD_W-1:0]         best_hd,
  output logic [HD_W-1:0]         second_hd,
  output logic                    match_ok,
  output logic [IDX_W-1:0]        cand_cnt,
  output logic                    cnt_ovf,
  output logic [2:0]              dbg_state
);

  localparam logic [HD_W-1:0] HD_ALL = HD_SENTINEL[HD_W-1:0];
  localparam int              CW     = HD_W + 4;

  match_state_e state_q, state_d;

  logic               accept;
  logic               start_search;
  logic [HD_W-1:0]    pipe_hd;
  logic               pipe_vld;
  logic               pipe_last;
  logic [COOR_W-1:0]  pipe_coor;

  logic [HDC_LAT-1:0] sp_vld_q;
  logic [HDC_LAT-1:0] sp_last_q;
  logic [COOR_W-1:0]  sp_coor_q [HDC_LAT];

  logic [HD_W-1:0]    best_q, second_q;
  logic [IDX_W-1:0]   best_idx_q, cnt_q;
  logic [COOR_W-1:0]  best_coor_q;
  logic               ovf_q, match_ok_q, match_ok_d;
  logic [CW-1:0]      best_x16, ratio_prod;

  // The main coordinate is carried with the descriptor but never evaluated.
  logic unused_main_coor;
  assign unused_main_coor = ^coor_des_main[COOR_W+DES_W-1:DES_W];

  assign s_ready      = (state_q == SEARCH);
  assign m_valid      = (state_q == HOLD);
  assign accept       = s_valid && s_ready;
  assign start_search = (state_q == IDLE) && start;

  hdc_param #(
    .DES_W   (DES_W),
    .HDC_LAT (HDC_LAT),
    .HD_W    (HD_W)
  ) u_hdc (
    .clk_i (clk),
    .a_i   (coor_des_main[DES_W-1:0]),
    .b_i   (coor_des_slave[DES_W-1:0]),
    .hd_o  (pipe_hd)
  );

  // Valid side pipe, aligned with the popcount latency; flushed by clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      sp_vld_q <= '0;
    end else begin
      sp_vld_q[0] <= accept;
      for (int k = 1; k < HDC_LAT; k++) sp_vld_q[k] <= sp_vld_q[k-1];
    end
  end

  // Coordinate/last side pipe; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    sp_coor_q[0] <= coor_des_slave[COOR_W+DES_W-1:DES_W];
    sp_last_q[0] <= s_last;
    for (int k = 1; k < HDC_LAT; k++) begin
      sp_coor_q[k] <= sp_coor_q[k-1];
      sp_last_q[k] <= sp_last_q[k-1];
    end
  end

  assign pipe_vld  = sp_vld_q[HDC_LAT-1];
  assign pipe_last = sp_last_q[HDC_LAT-1];
  assign pipe_coor = sp_coor_q[HDC_LAT-1];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SEARCH;
      SEARCH:  if (accept && s_last) state_d = DRAIN;
      DRAIN:   if (pipe_vld && pipe_last) state_d = DONE;
      DONE:    state_d = HOLD;
      HOLD:    if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Threshold and ratio test on the final best/second distances.
  assign best_x16   = {best_q, 4'b0000};
  assign ratio_prod = CW'(ratio_q4) * CW'(second_q);
  assign match_ok_d = (best_q <= max_hd) && (best_q != HD_ALL) && (best_x16 < ratio_prod);

  // Best/second tracker, candidate counter and result register.
  always_ff @(posedge clk) begin
    if (clear || start_search) begin
      best_q      <= HD_ALL;
      second_q    <= HD_ALL;
      best_idx_q  <= '0;
      best_coor_q <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      match_ok_q  <= 1'b0;
    end else begin
      if (pipe_vld) begin
        if (pipe_hd < best_q) begin
          second_q    <= best_q;
          best_q      <= pipe_hd;
          best_idx_q  <= cnt_q;
          best_coor_q <= pipe_coor;
        end else if (pipe_hd < second_q) begin
          second_q <= pipe_hd;
        end
        if (&cnt_q) ovf_q <= 1'b1;
        else        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == DONE) match_ok_q <= match_ok_d;
    end
  end

  assign best_idx  = best_idx_q;
  assign best_coor = best_coor_q;
  assign best_hd   = best_q;
  assign second_hd = second_q;
  assign match_ok  = match_ok_q;
  assign cand_cnt  = cnt_q;
  assign cnt_ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule
